misc_fifo_pack: RTL and testbench

//  Single-clock, parametrised successor to the misc record FIFO. Packs RATIO narrow

---
 rtl/misc_fifo_pack.sv | 175 +++++++++++++++++
 tb/tb_misc_fifo_pack.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/misc_fifo_pack.sv
// -----------------------------------------------------------------------------
// misc_fifo_pack
//   Packs RATIO narrow misc records into one OUT_W-bit DMA word and buffers the
//   words in a DEPTH-deep single-clock FIFO. Raises a registered burst read
//   request once BURST words are stored. A flush zero-pads the current contents
//   up to a burst boundary and then holds BUSY until the buffer has drained.
//
// Ports
//   iCLK, iRST_N        clock, synchronous active-low reset
//   iMISC_DATA/_PUSH    input record and its valid (one record per cycle)
//   iMISC_FLUSH         pulse: pad to a burst boundary, then drain
//   iMISC_POP           read one output word (data appears one cycle later)
//   oMISC_DATA/_V       registered output word and its one-cycle valid pulse
//   oMISC_FIFO_FULL     usedw == DEPTH
//   oMISC_FIFO_EMPTY    usedw == 0
//   oMISC_FIFO_USEDW    stored output words (AW+1 bits)
//   oMISC_FIFO_RD_REQ   registered, usedw >= BURST
//   oMISC_FIFO_BUSY     flush/drain in progress, pushes refused
//   oMISC_DROP_CNT      refused pushes, saturating
// -----------------------------------------------------------------------------
module misc_fifo_pack #(
   parameter  int IN_W  = 128,
   parameter  int RATIO = 2,
   parameter  int DEPTH = 256,
   parameter  int BURST = 16,
   localparam int OUT_W = IN_W * RATIO,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic [IN_W-1:0]  iMISC_DATA,
   input  logic             iMISC_PUSH,
   input  logic             iMISC_FLUSH,
   input  logic             iMISC_POP,
   output logic [OUT_W-1:0] oMISC_DATA,
   output logic             oMISC_DATA_V,
   output logic             oMISC_FIFO_FULL,
   output logic             oMISC_FIFO_EMPTY,
   output logic [AW:0]      oMISC_FIFO_USEDW,
   output logic             oMISC_FIFO_RD_REQ,
   output logic             oMISC_FIFO_BUSY,
   output logic [15:0]      oMISC_DROP_CNT
);

   localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int BW = $clog2(BURST);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_PAD, S_DRAIN} state_t;

   state_t             r_state, w_state_nxt;
   logic [OUT_W-1:0]   r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
   logic [AW:0]        r_cnt;
   logic [LW-1:0]      r_lane, w_lane_nxt;
   logic [OUT_W-1:0]   r_pack, w_pack_nxt, w_wr_data, r_data;
   logic               r_data_v, r_rd_req;
   logic [15:0]        r_drop;
   logic               w_full, w_empty, w_pop, w_blocked, w_wr, w_drop, w_aligned;

   assign w_full    = (r_cnt == (AW+1)'(DEPTH));
   assign w_empty   = (r_cnt == '0);
   assign w_pop     = iMISC_POP && !w_empty;
   // A pop in the same cycle frees the slot, so full+pop+write is accepted.
   assign w_blocked = w_full && !w_pop;
   // Total words written (usedw + pops) sits on a burst boundary.
   assign w_aligned = (r_wr_ptr[BW-1:0] == '0);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      w_state_nxt = r_state;
      w_pack_nxt  = r_pack;
      w_lane_nxt  = r_lane;
      w_wr        = 1'b0;
      w_wr_data   = '0;
      w_drop      = 1'b0;
      case (r_state)
         S_IDLE, S_ACC: begin
            if (iMISC_PUSH) begin
               // Storage full: the record is refused outright, even into an
               // empty lane, and the block falls into the pad/drain sequence.
               if (w_blocked) begin
                  w_drop = 1'b1;
               end else begin
                  for (int k = 0; k < RATIO; k++) begin
                     if (r_lane == LW'(k)) w_pack_nxt[k*IN_W +: IN_W] = iMISC_DATA;
                  end
                  if (r_lane == LW'(RATIO-1)) begin
                     w_wr       = 1'b1;
                     w_wr_data  = w_pack_nxt;
                     // Cleared so unfilled lanes read as zero when padding.
                     w_pack_nxt = '0;
                     w_lane_nxt = '0;
                  end else begin
                     w_lane_nxt = r_lane + LW'(1);
                  end
               end
            end
            if (w_drop || (iMISC_FLUSH && !(w_empty && r_lane == '0 && !iMISC_PUSH)))
               w_state_nxt = S_PAD;
            else if (w_lane_nxt != '0)
               w_state_nxt = S_ACC;
            else
               w_state_nxt = S_IDLE;
         end
         S_PAD: begin
            w_drop = iMISC_PUSH;
            if (r_lane != '0) begin
               if (!w_blocked) begin
                  w_wr       = 1'b1;
                  w_wr_data  = r_pack;
                  w_pack_nxt = '0;
                  w_lane_nxt = '0;
               end
            end else if (w_aligned) begin
               w_state_nxt = S_DRAIN;
            end else if (!w_blocked) begin
               w_wr = 1'b1;
            end
         end
         S_DRAIN: begin
            w_drop = iMISC_PUSH;
            // Leave on the edge that empties the buffer, so BUSY and EMPTY move together.
            if (w_empty || (r_cnt == (AW+1)'(1) && w_pop)) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         r_state  <= S_IDLE;
         r_pack   <= '0;
         r_lane   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_data   <= '0;
         r_data_v <= 1'b0;
         r_rd_req <= 1'b0;
         r_drop   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_pack   <= w_pack_nxt;
         r_lane   <= w_lane_nxt;
         if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
         r_data_v <= w_pop;
         if (w_pop) r_data <= r_mem[r_rd_ptr];
         // Registered from the occupancy settled at the previous edge.
         r_rd_req <= (r_cnt >= (AW+1)'(BURST));
         if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
   end

   // NOTE: the storage array has no reset; pointers and count define which entries are valid.
   always_ff @(posedge iCLK) begin
      if (w_wr) r_mem[r_wr_ptr] <= w_wr_data;
   end

   assign oMISC_DATA        = r_data;
   assign oMISC_DATA_V      = r_data_v;
   assign oMISC_FIFO_FULL   = w_full;
   assign oMISC_FIFO_EMPTY  = w_empty;
   assign oMISC_FIFO_USEDW  = r_cnt;
   assign oMISC_FIFO_RD_REQ = r_rd_req;
   assign oMISC_FIFO_BUSY   = (r_state == S_PAD) || (r_state == S_DRAIN);
   assign oMISC_DROP_CNT    = r_drop;

endmodule

// File: tb/tb_misc_fifo_pack.sv
// -----------------------------------------------------------------------------
// tb_misc_fifo_pack
//   Self-checking bench for misc_fifo_pack. Expected output words are pushed to
//   a scoreboard queue when a pop is driven and compared when DATA_V appears.
// -----------------------------------------------------------------------------
module tb_misc_fifo_pack #(
   parameter int IN_W  = 32,
   parameter int RATIO = 2,
   parameter int DEPTH = 256,
   parameter int BURST = 16
);

   localparam int OUT_W = IN_W * RATIO;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = (OUT_W > 32) ? OUT_W : 32;

   logic             iCLK = 1'b0;
   logic             iRST_N;
   logic [IN_W-1:0]  iMISC_DATA;
   logic             iMISC_PUSH, iMISC_FLUSH, iMISC_POP;
   logic [OUT_W-1:0] oMISC_DATA;
   logic             oMISC_DATA_V, oMISC_FIFO_FULL, oMISC_FIFO_EMPTY;
   logic [AW:0]      oMISC_FIFO_USEDW;
   logic             oMISC_FIFO_RD_REQ, oMISC_FIFO_BUSY;
   logic [15:0]      oMISC_DROP_CNT;

   misc_fifo_pack #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .BURST(BURST)) dut (
      .iCLK              (iCLK),
      .iRST_N            (iRST_N),
      .iMISC_DATA        (iMISC_DATA),
      .iMISC_PUSH        (iMISC_PUSH),
      .iMISC_FLUSH       (iMISC_FLUSH),
      .iMISC_POP         (iMISC_POP),
      .oMISC_DATA        (oMISC_DATA),
      .oMISC_DATA_V      (oMISC_DATA_V),
      .oMISC_FIFO_FULL   (oMISC_FIFO_FULL),
      .oMISC_FIFO_EMPTY  (oMISC_FIFO_EMPTY),
      .oMISC_FIFO_USEDW  (oMISC_FIFO_USEDW),
      .oMISC_FIFO_RD_REQ (oMISC_FIFO_RD_REQ),
      .oMISC_FIFO_BUSY   (oMISC_FIFO_BUSY),
      .oMISC_DROP_CNT    (oMISC_DROP_CNT)
   );

   always #5 iCLK = ~iCLK;

   int n_chk  = 0;
   int n_fail = 0;
   int n_dv   = 0;
   int dv0;

   // Reference model: pack register, stored words, words written since reset.
   logic [OUT_W-1:0] m_pack;
   int               m_lane;
   int               m_wr;
   logic [OUT_W-1:0] m_store[$];
   logic [OUT_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, sample #1 after the edge.
   // 'acc' says whether the bench expects this push to be accepted.
   task automatic step(input bit push, input bit acc, input bit pop, input bit flush);
      logic [IN_W-1:0] d;
      d = IN_W'({$urandom, $urandom});
      if (pop && m_store.size() > 0) exp_q.push_back(m_store.pop_front());
      if (push && acc) begin
         m_pack[m_lane*IN_W +: IN_W] = d;
         m_lane++;
         if (m_lane == RATIO) begin
            m_store.push_back(m_pack);
            m_pack = '0;
            m_lane = 0;
            m_wr++;
         end
      end
      iMISC_PUSH  = push;
      iMISC_DATA  = d;
      iMISC_POP   = pop;
      iMISC_FLUSH = flush;
      @(posedge iCLK);
      #1;
      iMISC_PUSH  = 1'b0;
      iMISC_POP   = 1'b0;
      iMISC_FLUSH = 1'b0;
   endtask

   task automatic model_pad();
      if (m_lane != 0) begin
         m_store.push_back(m_pack);
         m_pack = '0;
         m_lane = 0;
         m_wr++;
      end
      while (m_wr % BURST != 0) begin
         m_store.push_back('0);
         m_wr++;
      end
   endtask

   task automatic model_clear();
      m_store.delete();
      exp_q.delete();
      m_pack = '0;
      m_lane = 0;
      m_wr   = 0;
   endtask

   task automatic reset_dut();
      step(0, 0, 0, 0);
      iRST_N = 1'b0;
      repeat (2) @(posedge iCLK);
      #1;
      iRST_N = 1'b1;
      model_clear();
   endtask

   // Output monitor: every DATA_V pulse is matched against the scoreboard.
   always @(negedge iCLK) begin
      if (iRST_N && oMISC_DATA_V) begin
         n_dv++;
         if (exp_q.size() == 0) check("dv_unexpected", CW'(oMISC_DATA_V), CW'(0));
         else                   check("pop_data", CW'(oMISC_DATA), CW'(exp_q.pop_front()));
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      iRST_N      = 1'b0;
      iMISC_DATA  = '0;
      iMISC_PUSH  = 1'b0;
      iMISC_FLUSH = 1'b0;
      iMISC_POP   = 1'b0;
      model_clear();
      reset_dut();

      // Reset state
      check("rst_empty",  CW'(oMISC_FIFO_EMPTY),  CW'(1));
      check("rst_full",   CW'(oMISC_FIFO_FULL),   CW'(0));
      check("rst_usedw",  CW'(oMISC_FIFO_USEDW),  CW'(0));
      check("rst_rd_req", CW'(oMISC_FIFO_RD_REQ), CW'(0));
      check("rst_busy",   CW'(oMISC_FIFO_BUSY),   CW'(0));
      check("rst_drop",   CW'(oMISC_DROP_CNT),    CW'(0));
      check("rst_dv",     CW'(oMISC_DATA_V),      CW'(0));
      check("rst_data",   CW'(oMISC_DATA),        CW'(0));

      // Four records pack into 4/RATIO words, lane 0 in the low bits
      dv0 = n_dv;
      repeat (4) step(1, 1, 0, 0);
      check("s1_usedw",  CW'(oMISC_FIFO_USEDW),  CW'(4 / RATIO));
      check("s1_rd_req", CW'(oMISC_FIFO_RD_REQ), CW'(0));
      repeat (4 / RATIO) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      check("s1_dv_cnt", CW'(n_dv - dv0), CW'(4 / RATIO));
      check("s1_empty",  CW'(oMISC_FIFO_EMPTY), CW'(1));

      // One burst: RD_REQ lags usedw by one cycle, then 16 ordered pops
      reset_dut();
      dv0 = n_dv;
      repeat (BURST * RATIO) step(1, 1, 0, 0);
      check("s2_usedw",      CW'(oMISC_FIFO_USEDW),  CW'(BURST));
      check("s2_rdreq_lag",  CW'(oMISC_FIFO_RD_REQ), CW'(0));
      step(0, 0, 0, 0);
      check("s2_rdreq",      CW'(oMISC_FIFO_RD_REQ), CW'(1));
      repeat (BURST) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      check("s2_dv_cnt",     CW'(n_dv - dv0), CW'(BURST));
      check("s2_rdreq_drop", CW'(oMISC_FIFO_RD_REQ), CW'(0));
      check("s2_empty",      CW'(oMISC_FIFO_EMPTY),  CW'(1));

      // Flush with a partial word: pad to a burst, BUSY until fully drained
      reset_dut();
      repeat (3) step(1, 1, 0, 0);
      step(0, 0, 0, 1);
      model_pad();
      check("s3_busy_flush", CW'(oMISC_FIFO_BUSY), CW'(1));
      for (int i = 0; i < 4 * BURST && oMISC_FIFO_USEDW != (AW+1)'(BURST); i++) step(0, 0, 0, 0);
      check("s3_usedw", CW'(oMISC_FIFO_USEDW), CW'(BURST));
      step(1, 0, 0, 0);
      check("s3_drop_busy", CW'(oMISC_DROP_CNT), CW'(1));
      repeat (BURST - 1) step(0, 0, 1, 0);
      check("s3_busy_drain", CW'(oMISC_FIFO_BUSY), CW'(1));
      step(0, 0, 1, 0);
      check("s3_busy_done",  CW'(oMISC_FIFO_BUSY),  CW'(0));
      check("s3_empty",      CW'(oMISC_FIFO_EMPTY), CW'(1));

      // Fill to DEPTH, overflow by 5, then pop with a simultaneous push
      reset_dut();
      repeat (DEPTH * RATIO) step(1, 1, 0, 0);
      check("s4_full",  CW'(oMISC_FIFO_FULL),  CW'(1));
      check("s4_usedw", CW'(oMISC_FIFO_USEDW), CW'(DEPTH));
      check("s4_busy0", CW'(oMISC_FIFO_BUSY),  CW'(0));
      repeat (5) step(1, 0, 0, 0);
      check("s4_drop5", CW'(oMISC_DROP_CNT),  CW'(5));
      check("s4_busy1", CW'(oMISC_FIFO_BUSY), CW'(1));
      check("s4_full2", CW'(oMISC_FIFO_FULL), CW'(1));
      step(1, 0, 1, 0);
      check("s4_usedw_pop", CW'(oMISC_FIFO_USEDW), CW'(DEPTH - 1));
      check("s4_drop6",     CW'(oMISC_DROP_CNT),   CW'(6));
      repeat (DEPTH - 1) step(0, 0, 1, 0);
      check("s4_empty", CW'(oMISC_FIFO_EMPTY), CW'(1));
      check("s4_idle",  CW'(oMISC_FIFO_BUSY),  CW'(0));

      // Streaming through 3*DEPTH words exercises pointer wrap
      reset_dut();
      dv0 = n_dv;
      for (int w = 0; w < 3 * DEPTH; w++)
         for (int k = 0; k < RATIO; k++) step(1, 1, (k == 0), 0);
      repeat (4) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      check("s5_dv_cnt", CW'(n_dv - dv0), CW'(3 * DEPTH));
      check("s5_empty",  CW'(oMISC_FIFO_EMPTY), CW'(1));

      // Pop while empty is ignored
      reset_dut();
      step(0, 0, 1, 0);
      check("s6_dv",    CW'(oMISC_DATA_V),     CW'(0));
      check("s6_usedw", CW'(oMISC_FIFO_USEDW), CW'(0));

      // Reset in the middle of padding aborts the flush
      repeat (3) step(1, 1, 0, 0);
      step(0, 0, 0, 1);
      step(1, 0, 0, 0);
      check("s7_busy_pad", CW'(oMISC_FIFO_BUSY), CW'(1));
      check("s7_drop_pad", CW'(oMISC_DROP_CNT),  CW'(1));
      iRST_N = 1'b0;
      @(posedge iCLK);
      #1;
      iRST_N = 1'b1;
      model_clear();
      check("s7_empty", CW'(oMISC_FIFO_EMPTY), CW'(1));
      check("s7_busy",  CW'(oMISC_FIFO_BUSY),  CW'(0));
      check("s7_drop",  CW'(oMISC_DROP_CNT),   CW'(0));
      check("s7_usedw", CW'(oMISC_FIFO_USEDW), CW'(0));

      step(0, 0, 0, 0);
      check("sb_drained", CW'(exp_q.size()), CW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
